// File: rtl/pathfinding_pkg.sv
// pathfinding_pkg: shared widths, explored-node RAM entry layout and unwinder states
package pathfinding_pkg;
    localparam int ID_W = 16;
    localparam int COORD_W = 16;
    localparam logic [ID_W-1:0] NULL_ID = 16'hFFFF;
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [ID_W-1:0]    parent_id;
    } explored_entry_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_PUSH,
        S_EMIT,
        S_DONE,
        S_ERR
    } unw_state_t;
endpackage

// File: rtl/path_unwinder_if.sv
// path_unwinder_if: waypoint valid/ready stream from the unwinder to the HPS bridge
interface path_unwinder_if;
    import pathfinding_pkg::*;
    logic               wp_valid;
    logic               wp_ready;
    logic               wp_last;
    logic [COORD_W-1:0] wp_x;
    logic [COORD_W-1:0] wp_y;
    modport master (output wp_valid, wp_x, wp_y, wp_last, input wp_ready);
    modport slave (input wp_valid, wp_x, wp_y, wp_last, output wp_ready);
endinterface

// File: rtl/path_lifo.sv
// path_lifo: register-array stack that reverses the goal-to-start walk
module path_lifo #(
    parameter int W = 32,
    parameter int DEPTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [W-1:0]           i_din,
    output logic [W-1:0]           o_top,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_cnt;
    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_top_ptr;
    assign w_wr_ptr  = r_cnt[AW-1:0];
    assign w_top_ptr = w_wr_ptr - AW'(1);
    assign o_top     = r_mem[w_top_ptr];
    assign o_empty   = r_cnt == '0;
    assign o_full    = r_cnt == (AW+1)'(DEPTH);
    assign o_count   = r_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else if (i_flush) r_cnt <= '0;
        else if (i_push && !o_full) r_cnt <= r_cnt + 1'b1;
        else if (i_pop && !o_empty) r_cnt <= r_cnt - 1'b1;
    always_ff @(posedge clk)
        if (i_push && !o_full) r_mem[w_wr_ptr] <= i_din;
    assert property (@(posedge clk) disable iff (!rst_n) !(i_push && i_pop));
endmodule

// File: rtl/path_unwinder.sv
// path_unwinder: walks parent pointers goal->start, then streams waypoints start->goal
module path_unwinder
    import pathfinding_pkg::*;
#(
    parameter int MAX_PATH = 128
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_start,
    input  logic [ID_W-1:0]           i_start_id,
    input  logic [ID_W-1:0]           i_goal_id,
    output logic [ID_W-1:0]           o_nd_rd_addr,
    input  explored_entry_t           i_nd_rd_data,
    path_unwinder_if.master           wp,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [$clog2(MAX_PATH):0] o_path_len
);
    localparam int LW = $clog2(MAX_PATH) + 1;
    unw_state_t           r_state;
    unw_state_t           w_next;
    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [ID_W-1:0]      r_start_id;
    logic [ID_W-1:0]      r_cur_id;
    logic [LW-1:0]        r_path_len;
    logic [LW-1:0]        w_len_inc;
    logic                 r_error;
    logic                 r_wp_valid;
    logic                 r_wp_last;
    logic [COORD_W-1:0]   r_wp_x;
    logic [COORD_W-1:0]   r_wp_y;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_at_start;
    logic                 w_overflow;
    logic                 w_bad_parent;
    logic                 w_hs;
    logic [2*COORD_W-1:0] w_top;
    logic [LW-1:0]        w_count;
    // reset asserts immediately but releases on a clock edge
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_rst_sync <= '0;
        else r_rst_sync <= {r_rst_sync[0], 1'b1};
    assign w_rst_n      = r_rst_sync[1];
    assign w_len_inc    = r_path_len + 1'b1;
    assign w_at_start   = r_cur_id == r_start_id;
    assign w_overflow   = w_len_inc == LW'(MAX_PATH);
    assign w_bad_parent = i_nd_rd_data.parent_id == NULL_ID || i_nd_rd_data.parent_id == r_cur_id;
    assign w_hs         = r_wp_valid && wp.wp_ready;
    assign w_push       = r_state == S_PUSH && !w_full;
    assign w_pop        = r_state == S_EMIT && !w_empty && (!r_wp_valid || (w_hs && !r_wp_last));
    assign w_flush      = r_state == S_ERR;
    path_lifo #(.W(2*COORD_W), .DEPTH(MAX_PATH)) u_lifo (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   ({i_nd_rd_data.x, i_nd_rd_data.y}),
        .o_top   (w_top),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_ADDR : S_IDLE;
            S_ADDR:  w_next = S_WAIT;
            S_WAIT:  w_next = S_PUSH;
            S_PUSH:  w_next = w_at_start ? S_EMIT : (w_overflow || w_bad_parent) ? S_ERR : S_ADDR;
            S_EMIT:  w_next = (w_hs && r_wp_last) ? S_DONE : S_EMIT;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge w_rst_n)
        if (!w_rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    always_ff @(posedge clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_start_id <= '0;
            r_cur_id   <= '0;
            r_path_len <= '0;
            r_error    <= 1'b0;
            r_wp_valid <= 1'b0;
            r_wp_last  <= 1'b0;
            r_wp_x     <= '0;
            r_wp_y     <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_start_id <= i_start_id;
                r_cur_id   <= i_goal_id;
                r_path_len <= '0;
                r_error    <= 1'b0;
            end
            if (r_state == S_PUSH) begin
                r_path_len <= w_len_inc;
                if (!w_at_start && !w_overflow && !w_bad_parent) r_cur_id <= i_nd_rd_data.parent_id;
            end
            if (r_state == S_ERR) r_error <= 1'b1;
            // a non-last handshake reloads in the same cycle for 1 beat/cycle
            if (w_pop) begin
                r_wp_x     <= w_top[2*COORD_W-1:COORD_W];
                r_wp_y     <= w_top[COORD_W-1:0];
                r_wp_last  <= w_count == LW'(1);
                r_wp_valid <= 1'b1;
            end else if (w_hs) begin
                r_wp_valid <= 1'b0;
                r_wp_last  <= 1'b0;
            end
        end
    assign o_nd_rd_addr = r_cur_id;
    assign o_busy       = r_state != S_IDLE;
    assign o_done       = r_state == S_DONE;
    assign o_error      = r_error;
    assign o_path_len   = r_path_len;
    assign wp.wp_valid  = r_wp_valid;
    assign wp.wp_last   = r_wp_last;
    assign wp.wp_x      = r_wp_x;
    assign wp.wp_y      = r_wp_y;
endmodule

// File: tb/tb_path_unwinder.sv
// tb_path_unwinder: directed and random paths checked against a parent-chain walk model
module tb_path_unwinder;
    import pathfinding_pkg::*;
    localparam int MAXP = 128;
    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   start = 1'b0;
    logic [ID_W-1:0]        start_id = '0;
    logic [ID_W-1:0]        goal_id = '0;
    logic [ID_W-1:0]        nd_rd_addr;
    explored_entry_t        nd_rd_data;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [$clog2(MAXP):0]  path_len;
    explored_entry_t        mem [65536];
    int                     total = 0;
    int                     bad = 0;
    logic [31:0]            exp_q [$];
    bit                     m_err;
    int                     m_len;
    logic [ID_W-1:0]        sid;
    logic [ID_W-1:0]        gid;
    path_unwinder_if wp_if ();
    path_unwinder #(.MAX_PATH(MAXP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (start),
        .i_start_id   (start_id),
        .i_goal_id    (goal_id),
        .o_nd_rd_addr (nd_rd_addr),
        .i_nd_rd_data (nd_rd_data),
        .wp           (wp_if),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_path_len   (path_len)
    );
    always #5 clk = ~clk;
    always @(posedge clk) nd_rd_data <= mem[nd_rd_addr];
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic set_node(input logic [15:0] id, input logic [15:0] x, input logic [15:0] y, input logic [15:0] par);
        mem[id] = {x, y, par};
    endtask
    task automatic make_chain(input int n, input int base, output logic [15:0] s, output logic [15:0] g);
        for (int i = 0; i < n; i++)
            set_node(16'(base + i), 16'($urandom), 16'($urandom), i == 0 ? NULL_ID : 16'(base + i - 1));
        s = 16'(base);
        g = 16'(base + n - 1);
    endtask
    // reference: follow parents from the goal, collecting coordinates in start-first order
    task automatic model(input logic [15:0] s, input logic [15:0] g);
        logic [15:0] cur;
        explored_entry_t e;
        exp_q.delete();
        m_err = 1'b0;
        cur = g;
        while (1) begin
            e = mem[cur];
            exp_q.push_front({e.x, e.y});
            if (cur == s) break;
            if (exp_q.size() == MAXP || e.parent_id == NULL_ID || e.parent_id == cur) begin
                m_err = 1'b1;
                break;
            end
            cur = e.parent_id;
        end
        m_len = exp_q.size();
    endtask
    task automatic out_zero(input string tag);
        chk(tag, {busy, done, error, path_len, nd_rd_addr, wp_if.wp_valid, wp_if.wp_x, wp_if.wp_y, wp_if.wp_last}, '0);
    endtask
    task automatic do_run(input logic [15:0] s, input logic [15:0] g, input int pct, input int abort_after);
        int cyc, beats, dones, done_cyc, first_v, last_hs, busy_drop;
        bit stalled, rdy;
        logic [32:0] held;
        model(s, g);
        beats = 0; dones = 0; done_cyc = -1; first_v = -1; last_hs = -1; busy_drop = -1;
        stalled = 1'b0; held = '0;
        @(negedge clk);
        start = 1'b1; start_id = s; goal_id = g;
        wp_if.wp_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 3000) begin
            if (done) begin dones++; done_cyc = cyc; end
            if (wp_if.wp_valid && first_v < 0) first_v = cyc;
            if (stalled) chk("stall_hold", {wp_if.wp_valid, wp_if.wp_x, wp_if.wp_y, wp_if.wp_last}, {1'b1, held});
            if (!busy) begin busy_drop = cyc; break; end
            rdy = $urandom_range(99) < pct;
            wp_if.wp_ready = rdy;
            if (wp_if.wp_valid && rdy) begin
                chk("beat", {wp_if.wp_x, wp_if.wp_y, wp_if.wp_last}, {exp_q[beats], beats == m_len - 1});
                beats++;
                last_hs = cyc;
                if (beats == abort_after) return;
            end
            stalled = wp_if.wp_valid && !rdy;
            held = {wp_if.wp_x, wp_if.wp_y, wp_if.wp_last};
            @(negedge clk);
            cyc++;
        end
        wp_if.wp_ready = 1'b0;
        chk("terminated", busy_drop >= 0, 1);
        chk("error", error, m_err);
        if (!m_err) begin
            chk("beat_count", beats, m_len);
            chk("path_len", path_len, m_len);
            chk("done_count", dones, 1);
            chk("done_timing", done_cyc, last_hs + 1);
            chk("walk_cycles", first_v, 3 * m_len + 1);
            if (pct == 100) chk("back_to_back", last_hs - first_v, m_len - 1);
        end else begin
            chk("no_valid_on_err", first_v, -1);
            chk("no_done_on_err", dones, 0);
            chk("busy_drop_bound", busy_drop <= 3 * m_len + 2, 1);
        end
    endtask
    initial begin
        wp_if.wp_ready = 1'b0;
        #1;
        out_zero("reset_outputs");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        set_node(1, 10, 10, NULL_ID);
        set_node(3, 30, 10, 1);
        set_node(5, 50, 10, 3);
        do_run(1, 5, 100, 0);
        chk("chain3_len", path_len, 3);
        set_node(7, 4, 4, NULL_ID);
        do_run(7, 7, 100, 0);
        chk("single_len", path_len, 1);
        chk("single_err", error, 0);
        set_node(3, 30, 10, NULL_ID);
        do_run(1, 5, 100, 0);
        chk("null_parent_err", error, 1);
        set_node(3, 30, 10, 1);
        do_run(1, 5, 50, 0);
        chk("err_cleared", error, 0);
        set_node(9, 9, 9, 9);
        do_run(1, 9, 100, 0);
        chk("self_loop_err", error, 1);
        for (int i = 0; i < 130; i++) set_node(16'(300 + i), 16'(i), 16'(i), 16'(i == 129 ? 300 : 301 + i));
        do_run(1, 300, 100, 0);
        chk("cycle_err", error, 1);
        make_chain(20, 2000, sid, gid);
        do_run(sid, gid, 30, 0);
        do_run(sid, gid, 100, 0);
        make_chain(128, 20000, sid, gid);
        do_run(sid, gid, 100, 0);
        chk("max_len", path_len, 128);
        make_chain(129, 30000, sid, gid);
        do_run(sid, gid, 100, 0);
        chk("overflow_err", error, 1);
        for (int t = 0; t < 4; t++) begin
            make_chain($urandom_range(1, 30), 40000 + t * 100, sid, gid);
            do_run(sid, gid, $urandom_range(20, 100), 0);
        end
        make_chain(5, 5000, sid, gid);
        do_run(sid, gid, 100, 2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        out_zero("mid_emit_reset");
        @(negedge clk);
        reset_n = 1'b1;
        wp_if.wp_ready = 1'b0;
        repeat (3) @(negedge clk);
        do_run(sid, gid, 100, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
